program_loader: RTL and testbench

//  Boot-time stage upstream of full_system. Receives a program as a byte stream (valid/ready) and

---
 rtl/program_loader_pkg.sv | 15 +
 rtl/loader_word_assembler.sv | 29 ++
 rtl/program_loader.sv | 90 +++++++++
 tb/tb_program_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encodings, byte width and state helpers for the program loader
package program_loader_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;
  function automatic logic is_busy(input state_t s);
    return s == S_LEN || s == S_DATA || s == S_CSUM;
  endfunction
endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: pairs accepted stream bytes (high byte first) into instruction words
module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int IR_width = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                byte_stb,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                word_valid,
  output logic [IR_width-1:0] word
);
  logic                       phase;
  logic [IR_width-BYTE_W-1:0] hi;
  // phase toggles per accepted byte; the first byte's low bits become the word's top bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      hi    <= '0;
    end else begin
      phase <= clr ? 1'b0 : phase ^ byte_stb;
      if (byte_stb && !phase) hi <= byte_data[IR_width-BYTE_W-1:0];
    end
  end
  assign word_valid = byte_stb & phase;
  assign word       = {hi, byte_data};
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed, checksummed program into Ins_Memory and releases the cpu
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IR_width = 12,
  parameter int Im_width = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [Im_width-1:0] im_address,
  output logic [IR_width-1:0] im_data,
  output logic                im_wren,
  output logic                im_sel,
  output logic                cpu_reset,
  output logic                start,
  output logic                busy,
  output logic                error
);
  localparam logic [IR_width-1:0] MAX_LEN = IR_width'(2 ** Im_width);
  state_t                state, next;
  logic                  wv;
  logic [IR_width-1:0]   w, len, sum, cnt;
  logic [Im_width-1:0]   addr;
  loader_word_assembler #(.IR_width(IR_width)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (next != state),
    .byte_stb  (in_valid & in_ready),
    .byte_data (in_data),
    .word_valid(wv),
    .word      (w)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end
  // next-state decode from completed words and reload requests
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:       next = load_req ? S_LEN : S_IDLE;
      S_LEN:        if (wv) next = w > MAX_LEN ? S_ERR : w == '0 ? S_CSUM : S_DATA;
      S_DATA:       if (wv && cnt + IR_width'(1) == len) next = S_CSUM;
      S_CSUM:       if (wv) next = w == sum ? S_RUN : S_ERR;
      S_RUN, S_ERR: if (load_req) next = S_LEN;
      default:      next = S_IDLE;
    endcase
  end
  // registered outputs, write port, address/word counters and checksum accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len        <= '0;
      sum        <= '0;
      cnt        <= '0;
      addr       <= '0;
      im_address <= '0;
      im_data    <= '0;
      im_wren    <= 1'b0;
      cpu_reset  <= 1'b1;
      start      <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      busy      <= is_busy(next);
      error     <= next == S_ERR;
      cpu_reset <= next != S_RUN;
      start     <= next == S_RUN;
      im_wren   <= state == S_DATA && wv;
      if (state == S_LEN && wv) len <= w;
      if ((next == S_LEN && state != S_LEN) || (state == S_LEN && wv)) begin
        sum  <= '0;
        cnt  <= '0;
        addr <= '0;
      end else if (state == S_DATA && wv) begin
        im_address <= addr;
        im_data    <= w;
        addr       <= addr + Im_width'(1);
        cnt        <= cnt + IR_width'(1);
        sum        <= sum + w;
      end
    end
  end
  assign in_ready = busy;
  assign im_sel   = cpu_reset;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven image loads plus gap, full-length and reset-mid-load sequences
module tb_program_loader;
  logic        clk = 1'b0, reset = 1'b1, load_req = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, im_wren, im_sel, cpu_reset, start, busy, error;
  logic [7:0]  im_address;
  logic [11:0] im_data;
  int          nvec = 0, nbad = 0;
  logic [7:0]  wa[$];
  logic [11:0] wd[$];
  logic [11:0] img[$];
  bit          dbl = 0, prev = 0, noise = 0;
  logic [3:0]  junk = 4'h0;

  typedef struct packed {
    logic [11:0]      len;
    logic [3:0][11:0] w;
    logic [11:0]      csum;
    logic             err;
  } vec_t;
  vec_t vt[8];

  program_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_address(im_address), .im_data(im_data), .im_wren(im_wren),
    .im_sel(im_sel), .cpu_reset(cpu_reset), .start(start), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_wren) begin
      wa.push_back(im_address);
      wd.push_back(im_data);
    end
    if (im_wren && prev) dbl = 1;
    prev = im_wren;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  g;
    bit  ok;
    g  = noise ? int'($urandom_range(0, 3)) : 0;
    ok = 0;
    @(negedge clk);
    for (int i = 0; i < g; i++) begin
      load_req = noise && ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    load_req = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (t > 0) @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [11:0] w);
    send_byte({junk, w[11:8]});
    send_byte(w[7:0]);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_error_clr", error, 0);
    chk("load_start", start, 0);
    chk("load_cpu_reset", cpu_reset, 1);
  endtask

  task automatic run_image(input logic [11:0] len, input logic [11:0] csum);
    pulse_load();
    wa.delete();
    wd.delete();
    dbl = 0;
    send_word(len);
    if (len <= 12'h100) begin
      for (int j = 0; j < int'(len); j++) send_word(img[j]);
      send_word(csum);
    end
    @(negedge clk);
  endtask

  task automatic check_result(input string nm, input logic err, input int nw);
    chk({nm, "_error"}, error, err);
    chk({nm, "_start"}, start, !err);
    chk({nm, "_cpu_reset"}, cpu_reset, err);
    chk({nm, "_im_sel"}, im_sel, err);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_nwrites"}, wa.size(), nw);
    chk({nm, "_single_pulse"}, dbl, 0);
    for (int j = 0; j < nw && j < wa.size(); j++) begin
      chk({nm, "_waddr"}, wa[j], j);
      chk({nm, "_wdata"}, wd[j], img[j]);
    end
  endtask

  initial begin
    vt[0] = '{len: 12'h003, w: {12'h000, 12'h789, 12'h456, 12'h123}, csum: 12'hD02, err: 1'b0};
    vt[1] = '{len: 12'h003, w: {12'h000, 12'h789, 12'h456, 12'h123}, csum: 12'hD03, err: 1'b1};
    vt[2] = '{len: 12'h000, w: '0,                                     csum: 12'h000, err: 1'b0};
    vt[3] = '{len: 12'h000, w: '0,                                     csum: 12'h001, err: 1'b1};
    vt[4] = '{len: 12'h001, w: {12'h000, 12'h000, 12'h000, 12'hFFF}, csum: 12'hFFF, err: 1'b0};
    vt[5] = '{len: 12'h002, w: {12'h000, 12'h000, 12'h002, 12'hFFF}, csum: 12'h001, err: 1'b0};
    vt[6] = '{len: 12'h101, w: '0,                                     csum: 12'h000, err: 1'b1};
    vt[7] = '{len: 12'h004, w: {12'hABC, 12'h100, 12'h010, 12'h001}, csum: 12'hBCD, err: 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_im_address", im_address, 0);
    chk("rst_im_data", im_data, 0);
    chk("rst_im_wren", im_wren, 0);
    chk("rst_im_sel", im_sel, 1);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_start", start, 0);

    for (int i = 0; i < 8; i++) begin
      img.delete();
      for (int j = 0; j < 4 && j < int'(vt[i].len); j++) img.push_back(vt[i].w[j]);
      run_image(vt[i].len, vt[i].csum);
      check_result($sformatf("vec%0d", i), vt[i].err, vt[i].len > 12'h100 ? 0 : int'(vt[i].len));
    end

    img.delete();
    for (int j = 0; j < 256; j++) img.push_back(12'(j));
    run_image(12'h100, 12'hF80);
    check_result("len256", 1'b0, 256);
    chk("len256_last_addr", wa.size() == 256 ? wa[255] : 8'h00, 8'hFF);

    img.delete();
    img.push_back(12'h123);
    img.push_back(12'h456);
    img.push_back(12'h789);
    noise = 1;
    junk  = 4'h5;
    run_image(12'h003, 12'hD02);
    check_result("gaps", 1'b0, 3);
    noise = 0;
    junk  = 4'h0;

    pulse_load();
    send_word(12'h003);
    send_word(12'h123);
    chk("mid_wren", im_wren, 1);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wren", im_wren, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_start", start, 0);
    chk("post_rst_busy", busy, 0);
    wa.delete();
    wd.delete();
    dbl      = 0;
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    chk("idle_req_ready", in_ready, 0);
    @(negedge clk);
    load_req = 1'b0;
    chk("idle_req_ready_after", in_ready, 1);
    send_byte(8'h03);
    send_word(12'h123);
    send_word(12'h456);
    send_word(12'h789);
    send_word(12'hD02);
    @(negedge clk);
    check_result("reload", 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
